sm_phase_seq: RTL and testbench



---
 rtl/sm_phase_seq.sv | 179 +++++++++++++++++
 tb/tb_sm_phase_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_phase_seq.sv
// sm_phase_seq -- stepper-motor phase sequencer.
//
// Qualifies the incoming step-pulse train with a minimum-width filter. Each
// accepted pulse becomes one full or half step of a 4-coil drive pattern.
// The block keeps a signed position count with soft limits, and drops to a
// reduced-current hold state after a programmable idle time.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   drv_pulse         step pulse (active level selected by invert_pulse)
//   invert_pulse      1 = drv_pulse is active-low
//   drv_en_SM         motor enable, 0 = coils off
//   dir               1 = forward (+), 0 = reverse (-)
//   half_step         1 = half-step table, 0 = two-coil full-step
//   pos_clr           synchronous position clear (wins over a coincident step)
//   lim_lo, lim_hi    signed soft limits
//   phase             registered coil drive {A, B, A', B'}
//   hold_low          reduced hold current requested
//   position          signed step count
//   at_limit          last accepted pulse was blocked by a limit
//   step_strobe       one-cycle pulse per executed step
module sm_phase_seq #(
    parameter int SIZE        = 16,
    parameter int MIN_WIDTH   = 4,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            drv_pulse,
    input  logic            invert_pulse,
    input  logic            drv_en_SM,
    input  logic            dir,
    input  logic            half_step,
    input  logic            pos_clr,
    input  logic [SIZE-1:0] lim_lo,
    input  logic [SIZE-1:0] lim_hi,
    output logic [3:0]      phase,
    output logic            hold_low,
    output logic [SIZE-1:0] position,
    output logic            at_limit,
    output logic            step_strobe
);

    localparam int WW = $clog2(MIN_WIDTH + 1);
    localparam int IW = $clog2(HOLD_CYCLES + 1);
    localparam logic [SIZE-1:0] POS_ONE = SIZE'(1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state, w_state_nx;
    logic [WW-1:0]   r_wcnt, w_wcnt_nx;
    logic [IW-1:0]   r_idle, w_idle_nx;
    logic [2:0]      r_idx, w_idx_nx;
    logic [SIZE-1:0] r_pos, w_pos_nx;
    logic            r_at_lim, w_at_lim_nx;
    logic            r_strobe;
    logic [3:0]      r_phase, w_phase_nx;

    logic            w_p, w_accept, w_block, w_step;
    logic [2:0]      w_delta;

    function automatic logic [3:0] phase_lut(input logic [2:0] i);
        logic [3:0] v;
        case (i)
            3'd0:    v = 4'b1000;
            3'd1:    v = 4'b1100;
            3'd2:    v = 4'b0100;
            3'd3:    v = 4'b0110;
            3'd4:    v = 4'b0010;
            3'd5:    v = 4'b0011;
            3'd6:    v = 4'b0001;
            default: v = 4'b1001;
        endcase
        return v;
    endfunction

    always_comb begin
        w_p = drv_pulse ^ invert_pulse;
        // Acceptance fires on the cycle the width count reaches MIN_WIDTH, i.e.
        // while the registered count is still MIN_WIDTH-1. Gating with
        // drv_en_SM discards an acceptance that coincides with disable.
        w_accept = (r_state != S_OFF) && drv_en_SM && w_p &&
                   (r_wcnt == WW'(MIN_WIDTH - 1));
        w_block  = w_accept &&
                   (dir ? ($signed(r_pos) >= $signed(lim_hi))
                        : ($signed(r_pos) <= $signed(lim_lo)));
        w_step   = w_accept && !w_block;
        // Half-step moves one index. Full-step moves to the next odd (two-coil) index:
        // one from an even index, two from an odd one.
        w_delta  = (half_step || !r_idx[0]) ? 3'd1 : 3'd2;

        w_state_nx  = r_state;
        w_wcnt_nx   = r_wcnt;
        w_idle_nx   = r_idle;
        w_idx_nx    = r_idx;
        w_pos_nx    = r_pos;
        w_at_lim_nx = r_at_lim;
        w_phase_nx  = 4'b0000;

        case (r_state)
            S_OFF:   if (drv_en_SM) w_state_nx = S_RUN;
            S_RUN: begin
                if (!drv_en_SM)
                    w_state_nx = S_OFF;
                else if (!w_step && (r_idle >= IW'(HOLD_CYCLES - 1)))
                    w_state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (!drv_en_SM)
                    w_state_nx = S_OFF;
                else if (w_step)
                    w_state_nx = S_RUN;
            end
            default: w_state_nx = S_OFF;
        endcase

        // Width counter: saturates so only one acceptance per active period.
        if (r_state == S_OFF || !drv_en_SM || !w_p)
            w_wcnt_nx = '0;
        else if (r_wcnt != WW'(MIN_WIDTH))
            w_wcnt_nx = r_wcnt + 1'b1;

        // Idle counter: cycles since the last executed step. Blocked pulses
        // deliberately do not restart it.
        if (r_state == S_OFF || w_state_nx == S_OFF || w_step)
            w_idle_nx = '0;
        else if (r_idle != IW'(HOLD_CYCLES))
            w_idle_nx = r_idle + 1'b1;

        if (w_step)
            w_idx_nx = dir ? (r_idx + w_delta) : (r_idx - w_delta);

        if (pos_clr)
            w_pos_nx = '0;
        else if (w_step)
            w_pos_nx = dir ? (r_pos + POS_ONE) : (r_pos - POS_ONE);

        if (w_block)
            w_at_lim_nx = 1'b1;
        else if (w_step)
            w_at_lim_nx = 1'b0;

        if (w_state_nx != S_OFF)
            w_phase_nx = phase_lut(w_idx_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_OFF;
            r_wcnt   <= '0;
            r_idle   <= '0;
            r_idx    <= '0;
            r_pos    <= '0;
            r_at_lim <= 1'b0;
            r_strobe <= 1'b0;
            r_phase  <= 4'b0000;
        end else begin
            r_state  <= w_state_nx;
            r_wcnt   <= w_wcnt_nx;
            r_idle   <= w_idle_nx;
            r_idx    <= w_idx_nx;
            r_pos    <= w_pos_nx;
            r_at_lim <= w_at_lim_nx;
            r_strobe <= w_step;
            r_phase  <= w_phase_nx;
        end
    end

    assign phase       = r_phase;
    assign hold_low    = (r_state == S_HOLD);
    assign position    = r_pos;
    assign at_limit    = r_at_lim;
    assign step_strobe = r_strobe;

endmodule

// File: tb/tb_sm_phase_seq.sv
// Testbench for sm_phase_seq. A pulse-level reference model predicts the
// outcome of each pulse (step, block or filtered) and the resulting
// phase/position/at_limit values. The strobe is checked on every cycle.
module tb_sm_phase_seq;

    localparam int SIZE = 16;
    localparam int MW   = 4;
    localparam int HC   = 20;
    localparam logic [3:0] TBL [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                       4'b0010, 4'b0011, 4'b0001, 4'b1001};

    logic clk = 1'b0;
    logic rst_n, drv_pulse, invert_pulse, drv_en_SM, dir, half_step, pos_clr;
    logic signed [SIZE-1:0] lim_lo, lim_hi;
    logic [3:0]      phase;
    logic            hold_low, at_limit, step_strobe;
    logic [SIZE-1:0] position;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int      m_idx;
    shortint m_pos;
    bit      m_atl;
    bit      m_en;

    sm_phase_seq #(.SIZE(SIZE), .MIN_WIDTH(MW), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .rst_n(rst_n), .drv_pulse(drv_pulse), .invert_pulse(invert_pulse),
        .drv_en_SM(drv_en_SM), .dir(dir), .half_step(half_step), .pos_clr(pos_clr),
        .lim_lo(lim_lo), .lim_hi(lim_hi), .phase(phase), .hold_low(hold_low),
        .position(position), .at_limit(at_limit), .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        logic [15:0] mp;
        logic [3:0]  ep;
        mp = m_pos;
        ep = m_en ? TBL[m_idx] : 4'b0000;
        chk({tag, ".phase"},    {28'd0, phase},    {28'd0, ep});
        chk({tag, ".position"}, {16'd0, position}, {16'd0, mp});
        chk({tag, ".at_limit"}, {31'd0, at_limit}, {31'd0, m_atl});
    endtask

    // Outcome of one pulse with w active cycles, from the behavioural rules.
    task automatic model_pulse(input int w, output bit ex);
        int s;
        ex = 1'b0;
        if (m_en && w >= MW) begin
            if (dir ? (int'(m_pos) >= int'(lim_hi)) : (int'(m_pos) <= int'(lim_lo))) begin
                m_atl = 1'b1;
            end else begin
                s = dir ? 1 : -1;
                m_idx = ((m_idx + s) % 8 + 8) % 8;
                // full-step always lands on a two-coil (odd) index
                if (!half_step && (m_idx % 2 == 0))
                    m_idx = ((m_idx + s) % 8 + 8) % 8;
                m_pos = shortint'(int'(m_pos) + s);
                m_atl = 1'b0;
                ex = 1'b1;
            end
        end
    endtask

    // Drive w active cycles then gap idle cycles; pos_clr pulses on cycle clr_at.
    task automatic pulse(input int w, input int gap, input int clr_at);
        bit ex;
        model_pulse(w, ex);
        for (int k = 0; k < w + gap; k++) begin
            @(posedge clk); #1;
            drv_pulse = (k < w) ? ~invert_pulse : invert_pulse;
            pos_clr   = (k == clr_at);
            @(negedge clk);
            chk("strobe", {31'd0, step_strobe}, {31'd0, (ex && k == MW)});
        end
        pos_clr = 1'b0;
        if (clr_at >= 0) m_pos = 0;
        chk_state("pulse");
    endtask

    initial begin
        bit ex;
        rst_n = 1'b1; drv_pulse = 1'b0; invert_pulse = 1'b0; drv_en_SM = 1'b1;
        dir = 1'b1; half_step = 1'b1; pos_clr = 1'b0;
        lim_lo = 16'sh8000; lim_hi = 16'sh7fff;
        m_idx = 0; m_pos = 0; m_atl = 1'b0; m_en = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.phase",  {28'd0, phase},    32'd0);
        chk("rst.hold",   {31'd0, hold_low}, 32'd0);
        chk("rst.pos",    {16'd0, position}, 32'd0);
        chk("rst.atlim",  {31'd0, at_limit}, 32'd0);
        chk("rst.strobe", {31'd0, step_strobe}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("en.phase", {28'd0, phase}, {28'd0, 4'b1000});
        chk_state("en");

        // Half-step forward, 10 pulses
        for (int i = 0; i < 10; i++) pulse(8, 2, -1);
        chk("hs.phase", {28'd0, phase}, {28'd0, 4'b0100});
        chk("hs.pos",   {16'd0, position}, 32'd10);

        // Reset asserted mid-pulse takes effect immediately
        @(posedge clk); #1 drv_pulse = 1'b1;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("midrst.phase",  {28'd0, phase},    32'd0);
        chk("midrst.pos",    {16'd0, position}, 32'd0);
        chk("midrst.hold",   {31'd0, hold_low}, 32'd0);
        chk("midrst.atlim",  {31'd0, at_limit}, 32'd0);
        chk("midrst.strobe", {31'd0, step_strobe}, 32'd0);
        drv_pulse = 1'b0;
        m_idx = 0; m_pos = 0; m_atl = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk_state("midrst.rel");

        // Full-step reverse from idx 0
        dir = 1'b0; half_step = 1'b0;
        for (int i = 0; i < 3; i++) pulse(6, 2, -1);
        chk("fs.phase", {28'd0, phase},    {28'd0, 4'b0110});
        chk("fs.pos",   {16'd0, position}, {16'd0, 16'hfffd});

        // Width filter and polarity
        @(posedge clk); #1 invert_pulse = 1'b1; drv_pulse = 1'b1;
        dir = 1'b1; half_step = 1'b1;
        pulse(3, 3, -1);
        pulse(3, 3, -1);
        pulse(4, 3, -1);
        pulse(0, 10, -1);     // drv_pulse held high while active-low: no step
        chk("filt.pos", {16'd0, position}, {16'd0, 16'hfffe});

        // Limits
        @(posedge clk); #1 invert_pulse = 1'b0; drv_pulse = 1'b0; pos_clr = 1'b1;
        @(posedge clk); #1 pos_clr = 1'b0;
        m_pos = 0;
        @(negedge clk);
        chk("clr.pos", {16'd0, position}, 32'd0);
        lim_hi = 16'sd2; lim_lo = -16'sd100; dir = 1'b1;
        for (int i = 0; i < 4; i++) pulse(5, 2, -1);
        chk("lim.pos",   {16'd0, position}, 32'd2);
        chk("lim.atlim", {31'd0, at_limit}, 32'd1);
        dir = 1'b0;
        pulse(5, 2, -1);
        chk("lim.rev.pos",   {16'd0, position}, 32'd1);
        chk("lim.rev.atlim", {31'd0, at_limit}, 32'd0);
        dir = 1'b1;
        pulse(6, 3, MW - 1);  // pos_clr on the acceptance cycle
        chk("clrstep.pos", {16'd0, position}, 32'd0);

        // Hold entry/exit
        lim_hi = 16'sd1000; lim_lo = -16'sd1000;
        model_pulse(5, ex);
        for (int k = 0; k < MW + HC + 3; k++) begin
            @(posedge clk); #1 drv_pulse = (k < 5);
            @(negedge clk);
            chk("hold.strobe", {31'd0, step_strobe}, {31'd0, (ex && k == MW)});
            if (k >= MW) chk("hold.entry", {31'd0, hold_low}, {31'd0, (k >= MW + HC)});
        end
        model_pulse(5, ex);
        for (int k = 0; k < MW + 3; k++) begin
            @(posedge clk); #1 drv_pulse = (k < 5);
            @(negedge clk);
            chk("hold.exit.strobe", {31'd0, step_strobe}, {31'd0, (ex && k == MW)});
            chk("hold.exit", {31'd0, hold_low}, {31'd0, (k < MW)});
        end
        chk_state("hold");

        // Disable / re-enable
        @(posedge clk); #1 drv_en_SM = 1'b0;
        m_en = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("dis.phase", {28'd0, phase},    32'd0);
        chk("dis.hold",  {31'd0, hold_low}, 32'd0);
        pulse(6, 3, -1);
        @(posedge clk); #1 drv_en_SM = 1'b1;
        m_en = 1'b1;
        @(negedge clk); @(negedge clk);
        chk_state("reen");

        // Randomized pulses against the model
        for (int n = 0; n < 40; n++) begin
            int w, g;
            bit r;
            @(posedge clk); #1;
            r = 1'($urandom_range(0, 1));
            invert_pulse = r; drv_pulse = r;
            dir = 1'($urandom_range(0, 1));
            half_step = 1'($urandom_range(0, 1));
            if (n % 10 == 0) begin
                lim_lo = 16'(0 - int'($urandom_range(0, 6)));
                lim_hi = 16'(int'($urandom_range(0, 6)));
                if ($urandom_range(0, 3) == 0) begin
                    lim_lo = 16'sd3; lim_hi = -16'sd3;
                end
            end
            w = int'($urandom_range(1, 9));
            g = int'($urandom_range(1, 5));
            if (w + g < MW + 1) g = MW + 1 - w;
            pulse(w, g, ($urandom_range(0, 7) == 0) ? MW - 1 : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
